// File: rtl/date_step_counter.sv
// Registered calendar date counter: advances 0..3 days per request with month/year roll-over.
// Define REAL_MONTH_LEN_EN for Gregorian-style month lengths (Feb 29 when year[1:0]==0).
module date_step_counter #(
  parameter int unsigned DAYS_PER_MONTH  = 30,
  parameter int unsigned MONTHS_PER_YEAR = 12,
  parameter int unsigned YEAR_W          = 12,
  parameter int unsigned RESET_YEAR      = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4:0]        load_day,
  input  logic [3:0]        load_month,
  input  logic [YEAR_W-1:0] load_year,
  input  logic              adv,
  input  logic [1:0]        step,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              load_err
);

  localparam logic [4:0]        MaxMonth  = 5'(MONTHS_PER_YEAR);
  localparam logic [YEAR_W-1:0] ResetYear = YEAR_W'(RESET_YEAR);

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              month_wrap_q, month_wrap_d;
  logic              year_wrap_q, year_wrap_d;
  logic              load_err_q, load_err_d;

  logic [4:0] len_cur, len_load;
  logic [5:0] sum;
  logic       load_ok;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [YEAR_W-1:0] y);
`ifdef REAL_MONTH_LEN_EN
    case (m)
      4'd2:                      month_len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
`else
    logic unused;
    unused    = ^{m, y};
    month_len = 5'(DAYS_PER_MONTH);
`endif
  endfunction

  always_comb begin
    len_cur  = month_len(month_q, year_q);
    len_load = month_len(load_month, load_year);
    load_ok  = (load_day != 5'd0) && (load_day <= len_load) &&
               (load_month != 4'd0) && ({1'b0, load_month} <= MaxMonth);
    sum      = {1'b0, day_q} + {4'b0000, step};

    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;

    if (load) begin
      if (load_ok) begin
        day_d   = load_day;
        month_d = load_month;
        year_d  = load_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adv) begin
      if (sum <= {1'b0, len_cur}) begin
        day_d = sum[4:0];
      end else begin
        // len >= 28 and step <= 3, so a single month crossing is the worst case
        day_d        = 5'(sum - {1'b0, len_cur});
        month_wrap_d = 1'b1;
        if ({1'b0, month_q} < MaxMonth) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d     = 4'd1;
          year_d      = year_q + 1'b1;
          year_wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      year_q       <= ResetYear;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign load_err   = load_err_q;

endmodule
